axi_burst_writer: RTL

AXI4 write-only burst master that sits directly upstream of the AXI SRAM slave and drives its AW, W and B channels. It accepts a command (base address, beat count) and a valid/ready data stream. It splits the transfer into INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary, and signals completion with a status flag. It is the write engine used by DMA/loader logic to fill the SRAM.

---
 rtl/axi_burst_writer.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_writer.sv
// axi_burst_writer
//   AXI4 write-only burst master. Takes a (base address, beat count) command plus
//   a valid/ready data stream and issues INCR bursts of at most MAX_BURST beats
//   that never cross a 4 KB boundary. Only one burst is outstanding at a time,
//   and AW always completes before the first W beat of its burst.
//
// Ports
//   ACLK, ARESETn          clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is high only when idle
//   cmd_addr, cmd_beats    byte base address (sub-beat bits ignored), total beats
//                          (0 = no-op)
//   s_data/s_strb          write stream payload, forwarded to WDATA/WSTRB
//   s_valid/s_ready        write stream handshake
//   AW*/W*/B*              AXI4 write address, data and response channels
//   busy                   high whenever a command is in progress
//   done                   one-cycle pulse when a command finishes
//   err                    sticky: a SLVERR/DECERR was seen during the current
//                          command

module axi_burst_writer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // Command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_beats,
  // Write stream
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [STRB_WIDTH-1:0] s_strb,
  input  logic                  s_valid,
  output logic                  s_ready,
  // AXI write address channel
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  // AXI write response channel
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // Status
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned AddrLsb = $clog2(STRB_WIDTH);

  // Clears the sub-beat address bits so every burst is size-aligned.
  localparam logic [ADDR_WIDTH-1:0] AddrMask =
      ~((ADDR_WIDTH'(1) << AddrLsb) - ADDR_WIDTH'(1));

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StResp,
    StDone
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;     // start address of the current burst
  logic [15:0]           remain_q;   // beats not yet covered by a finished burst
  logic [15:0]           len_q;      // beats in the current burst
  logic [15:0]           beat_q;     // W beats still to send in the current burst
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  awvalid_q;
  logic                  done_q;
  logic                  err_q;

  // Burst length: limited by what is left, by MAX_BURST and by the room up to
  // the next 4 KB page. Offsets are beat-aligned so the room is at least 1.
  function automatic logic [15:0] burst_len(input logic [11:0] page_off,
                                            input logic [15:0] remain);
    logic [15:0] room;
    logic [15:0] len;
    room = (16'd4096 - {4'd0, page_off}) >> AddrLsb;
    len  = remain;
    if (len > 16'(MAX_BURST)) begin
      len = 16'(MAX_BURST);
    end
    if (len > room) begin
      len = room;
    end
    return len;
  endfunction

  logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [15:0]           next_remain;
  logic [15:0]           first_len;
  logic [15:0]           next_len;

  assign cmd_addr_aligned = cmd_addr & AddrMask;
  assign first_len        = burst_len(cmd_addr_aligned[11:0], cmd_beats);
  // Address and remaining count after the current burst retires (address wraps).
  assign next_addr        = addr_q + (ADDR_WIDTH'(len_q) << AddrLsb);
  assign next_remain      = remain_q - len_q;
  assign next_len         = burst_len(next_addr[11:0], next_remain);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      remain_q  <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // cmd_ready is high throughout this state, so cmd_valid is the handshake.
          if (cmd_valid) begin
            addr_q   <= cmd_addr_aligned;
            remain_q <= cmd_beats;
            err_q    <= 1'b0;
            if (cmd_beats == 16'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StAddr;
              len_q     <= first_len;
              awaddr_q  <= cmd_addr_aligned;
              awlen_q   <= 8'(first_len - 16'd1);
              awvalid_q <= 1'b1;
            end
          end
        end

        StAddr: begin
          // AW fields are registers that only change on entry, so they hold
          // steady until the handshake.
          if (AWREADY) begin
            awvalid_q <= 1'b0;
            beat_q    <= len_q;
            state_q   <= StData;
          end
        end

        StData: begin
          if (s_valid && WREADY) begin
            beat_q <= beat_q - 16'd1;
            if (beat_q == 16'd1) begin
              state_q <= StResp;
            end
          end
        end

        StResp: begin
          if (BVALID) begin
            // Error responses are recorded but the remaining bursts still go out.
            if (BRESP[1]) begin
              err_q <= 1'b1;
            end
            addr_q   <= next_addr;
            remain_q <= next_remain;
            if (next_remain == 16'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StAddr;
              len_q     <= next_len;
              awaddr_q  <= next_addr;
              awlen_q   <= 8'(next_len - 16'd1);
              awvalid_q <= 1'b1;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  logic in_data;
  assign in_data = (state_q == StData);

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

  assign AWADDR  = awaddr_q;
  assign AWLEN   = awlen_q;
  assign AWSIZE  = 3'(AddrLsb);
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;

  // W is a pass-through of the stream, opened only while a burst is in DATA.
  assign WVALID  = in_data & s_valid;
  assign WDATA   = s_data;
  assign WSTRB   = s_strb;
  assign WLAST   = in_data & (beat_q == 16'd1);
  assign s_ready = in_data & WREADY;

  assign BREADY  = (state_q == StResp);

  // Only BRESP[1] distinguishes the error responses that matter here.
  logic unused_bresp;
  assign unused_bresp = BRESP[0];

endmodule
